sipo_rx: RTL and testbench

Serial-in, parallel-out word receiver. It is the receive end of the team's MSB-first serial link and pairs with the `piso` transmitter. It assembles `WIDTH` serial bits into a parallel word, framed by a start-of-word marker. It pulses a valid strobe when each word completes and flags framing errors.

---
 rtl/sipo_rx.sv | 107 ++++++++++
 tb/tb_sipo_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH MSB-first bits framed by FRAME into DOUT.
// Latency: DOUT/DOUT_VALID update on the edge sampling the last bit; all outputs registered.
// Backpressure: none; accepts one bit per SIN_VALID cycle, unlimited gaps, resyncs on FRAME.
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN_VALID,
    input  logic             SIN,
    input  logic             FRAME,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic             FRAME_ERR,
    output logic             BUSY
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    // The first bit of a word seeds the shift register with the MSB in bit 0.
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] shifted;
    assign seed    = {{(WIDTH-1){1'b0}}, SIN};
    assign shifted = {sr_q[WIDTH-2:0], SIN};

    // Next-state and pulse generation; pulses default low so they last one cycle.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Unframed bits while idle are not aligned to any word and are dropped.
                if (SIN_VALID && FRAME) begin
                    sr_d    = seed;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (SIN_VALID) begin
                    if (FRAME) begin
                        // A new marker mid-word abandons the partial word, even on its last bit.
                        frame_err_d = 1'b1;
                        sr_d        = seed;
                        cnt_d       = CW'(1);
                    end else begin
                        sr_d = shifted;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            dout_d       = shifted;
                            dout_valid_d = 1'b1;
                            cnt_d        = '0;
                            state_d      = IDLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = dout_valid_q;
    assign FRAME_ERR  = frame_err_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: directed scenarios plus random bit streams against a word-level model.
// Checks every cycle ~1 time unit after the rising edge.
// Second instance at WIDTH=8 is fed from a shift-out loop acting as the transmitter.
module tb_sipo_rx;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         sin_valid = 1'b0, sin = 1'b0, frame = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid, frame_err, busy;

    logic         v8 = 1'b0, s8 = 1'b0, f8 = 1'b0;
    logic [7:0]   dout8;
    logic         dv8, fe8, busy8;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: count of bits held in the current word and their value.
    int           m_cnt = 0;
    logic [31:0]  m_val = 0;
    logic [W-1:0] m_dout = '0;
    logic         m_dv = 1'b0, m_fe = 1'b0;

    sipo_rx #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .SIN_VALID(sin_valid), .SIN(sin), .FRAME(frame),
        .DOUT(dout), .DOUT_VALID(dout_valid), .FRAME_ERR(frame_err), .BUSY(busy)
    );

    sipo_rx #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .SIN_VALID(v8), .SIN(s8), .FRAME(f8),
        .DOUT(dout8), .DOUT_VALID(dv8), .FRAME_ERR(fe8), .BUSY(busy8)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_val  = 0;
        m_dout = '0;
        m_dv   = 1'b0;
        m_fe   = 1'b0;
    endtask

    task automatic model_bit(input logic v, input logic s, input logic f);
        m_dv = 1'b0;
        m_fe = 1'b0;
        if (v) begin
            if (f) begin
                if (m_cnt > 0) m_fe = 1'b1;
                m_val = {31'd0, s};
                m_cnt = 1;
            end else if (m_cnt > 0) begin
                m_val = m_val * 2 + {31'd0, s};
                m_cnt++;
                if (m_cnt == W) begin
                    m_dout = m_val[W-1:0];
                    m_dv   = 1'b1;
                    m_cnt  = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"},  {28'd0, dout},       {28'd0, m_dout});
        chk({tag, ".dv"},    {31'd0, dout_valid}, {31'd0, m_dv});
        chk({tag, ".ferr"},  {31'd0, frame_err},  {31'd0, m_fe});
        chk({tag, ".busy"},  {31'd0, busy},       {31'd0, (m_cnt > 0)});
    endtask

    // One clock of stimulus on the WIDTH=4 instance, then model update and check.
    task automatic step(input string tag, input logic v, input logic s, input logic f);
        sin_valid = v;
        sin       = s;
        frame     = f;
        @(posedge CLK);
        model_bit(v, s, f);
        #1;
        check_all(tag);
    endtask

    task automatic send_word(input string tag, input logic [W-1:0] w, input int gap);
        for (int i = W - 1; i >= 0; i--) begin
            step(tag, 1'b1, w[i], (i == W - 1));
            for (int g = 0; g < gap && i > 0; g++) step(tag, 1'b0, 1'b1, 1'b1);
        end
    endtask

    // Transmit-side loop for the WIDTH=8 instance: FRAME rides with the loaded MSB.
    task automatic piso_send8(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            v8 = 1'b1;
            s8 = b[i];
            f8 = (i == 7);
            @(posedge CLK);
            #1;
            chk("w8.busy", {31'd0, busy8}, {31'd0, (i != 0)});
            chk("w8.dv",   {31'd0, dv8},   {31'd0, (i == 0)});
        end
        v8 = 1'b0;
        chk("w8.dout", {24'd0, dout8}, {24'd0, b});
        chk("w8.ferr", {31'd0, fe8},   32'd0);
    endtask

    initial begin
        logic [3:0] w;
        logic       rv, rs, rf;

        // Reset state
        #2;
        check_all("reset");
        chk("reset.dout8", {24'd0, dout8}, 32'd0);
        chk("reset.busy8", {31'd0, busy8}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // 1: single word 1011
        send_word("t1", 4'b1011, 0);
        chk("t1.dout_b", {28'd0, dout}, 32'hB);
        chk("t1.dv_b", {31'd0, dout_valid}, 32'd1);
        step("t1.idle", 1'b0, 1'b0, 1'b0);
        chk("t1.dv_drop", {31'd0, dout_valid}, 32'd0);

        // 2: unframed noise while idle, then gapped word 0110
        for (int i = 0; i < 3; i++) step("t2.noise", 1'b1, 1'b1, 1'b0);
        send_word("t2", 4'b0110, 2);
        chk("t2.dout", {28'd0, dout}, 32'h6);

        // 3: back-to-back words
        send_word("t3a", 4'b1100, 0);
        chk("t3.first", {28'd0, dout}, 32'hC);
        send_word("t3b", 4'b0011, 0);
        chk("t3.second", {28'd0, dout}, 32'h3);

        // 4: framing error then resumed word 1010
        step("t4", 1'b1, 1'b1, 1'b1);
        step("t4", 1'b1, 1'b0, 1'b0);
        step("t4", 1'b1, 1'b1, 1'b1);
        chk("t4.ferr", {31'd0, frame_err}, 32'd1);
        chk("t4.hold", {28'd0, dout}, 32'h3);
        step("t4", 1'b1, 1'b0, 1'b0);
        step("t4", 1'b1, 1'b1, 1'b0);
        step("t4", 1'b1, 1'b0, 1'b0);
        chk("t4.dout", {28'd0, dout}, 32'hA);

        // Resync on what would have been the last bit
        send_word("t4b.pre", 4'b1011, 0);
        step("t4b", 1'b1, 1'b1, 1'b1);
        step("t4b", 1'b1, 1'b0, 1'b0);
        step("t4b", 1'b1, 1'b0, 1'b0);
        step("t4b", 1'b1, 1'b1, 1'b1);
        chk("t4b.ferr", {31'd0, frame_err}, 32'd1);
        chk("t4b.dv", {31'd0, dout_valid}, 32'd0);

        // 5: async reset after two bits of a word
        send_word("t5.pre", 4'b1011, 0);
        step("t5", 1'b1, 1'b1, 1'b1);
        step("t5", 1'b1, 1'b0, 1'b0);
        step("t5", 1'b0, 1'b0, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_all("t5.rst");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        send_word("t5.post", 4'b1001, 0);
        chk("t5.dout", {28'd0, dout}, 32'h9);

        // Random streams against the model
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(3) != 0);
            rs = $urandom_range(1) != 0;
            rf = ($urandom_range(5) == 0);
            step("rand", rv, rs, rf);
        end
        for (int i = 0; i < 10; i++) begin
            w = 4'($urandom_range(15));
            send_word("rand.word", w, i % 3);
            chk("rand.word_val", {28'd0, dout}, {28'd0, w});
        end
        step("tail", 1'b0, 1'b0, 1'b0);

        // 6: WIDTH=8 loopback
        piso_send8(8'hA5);
        piso_send8(8'h3C);
        @(posedge CLK);
        #1;
        chk("w8.dv_drop", {31'd0, dv8}, 32'd0);
        chk("w8.final", {24'd0, dout8}, 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
